hazard_unit_p: RTL and testbench
================================

Name: hazard_unit_p

Overview:
- Parametrised successor to the single-cycle load-use hazard detector for the 5-stage MIPS pipeline; sits between the ID, EX, MEM and WB stage registers.
- Detects load-use hazards and holds PC and IF/ID for a configurable number of bubble cycles, tracked by a counter FSM.
- Also generates EX-stage forwarding selects, generates a one-cycle flush on a taken branch, and keeps a saturating count of stall cycles for performance debug.

Parameters:
- AW, 5, register-address width.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..15).
- CW, 16, width of the stall-cycle statistics counter.
- ZERO_SKIP, 1, when 1, register address 0 never causes a hazard or a forward.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  AW  rs field of the instruction in ID.
- id_rt  in  AW  rt field of the instruction in ID.
- ex_memr  in  1  instruction in EX is a load.
- ex_rt  in  AW  load destination (rt) of the instruction in EX.
- ex_rs_src  in  AW  rs operand address of the instruction in EX (forwarding).
- ex_rt_src  in  AW  rt operand address of the instruction in EX (forwarding).
- mem_regw  in  1  MEM-stage instruction writes the register file.
- mem_rd  in  AW  MEM-stage destination register.
- wb_regw  in  1  WB-stage instruction writes the register file.
- wb_rd  in  AW  WB-stage destination register.
- branch_taken  in  1  branch resolved taken in EX.
- pcw  out  1  PC write enable (0 = hold PC).
- s1w  out  1  IF/ID register write enable (0 = hold).
- mux  out  1  control select into ID/EX (1 = pass controls, 0 = insert bubble).
- flush  out  1  zero the IF/ID and ID/EX registers.
- fwd_a  out  2  EX operand-A source select.
- fwd_b  out  2  EX operand-B source select.
- stall_cycles  out  CW  saturating count of cycles with pcw=0.

Behaviour:
- Reset: state IDLE, counter 0, stall_cycles 0. While rst=1, outputs are forced to pcw=s1w=mux=1, flush=0, fwd_a=fwd_b=00, regardless of the other inputs.
- Hazard condition, combinational: hz = ex_memr && (ex_rt==id_rs || ex_rt==id_rt) && !(ZERO_SKIP && ex_rt==0).
- FSM states are IDLE and STALL.
  - IDLE with hz=1 and branch_taken=0: pcw=s1w=mux=0 in that same cycle (Mealy output). If LOAD_LAT>1, load cnt=LOAD_LAT-1 and go to STALL; if LOAD_LAT=1, stay in IDLE.
  - STALL: pcw=s1w=mux=0. cnt decrements each cycle. When cnt==1 on a clock edge, go to IDLE. The total stall is exactly LOAD_LAT cycles.
  - hz is ignored while in STALL; it is re-evaluated in the first IDLE cycle after the stall.
- branch_taken=1 in any state:
  - flush=1 for that cycle and pcw=1, so the branch target loads.
  - s1w=1, and mux=0 to squash the ID instruction.
  - Any STALL is aborted: go to IDLE, cnt=0.
  - Flush takes priority over a simultaneous hz.
- Forwarding, combinational, evaluated per operand (A uses ex_rs_src, B uses ex_rt_src):
  - 10 (MEM): mem_regw && mem_rd==src && src nonzero (when ZERO_SKIP).
  - else 01 (WB): wb_regw && wb_rd==src && src nonzero (when ZERO_SKIP).
  - else 00 (register file).
  - MEM has priority when both stages match.
- stall_cycles increments on each clock edge where pcw=0 and rst=0. It saturates at all-ones with no wrap.
- Reset asserted mid-stall: the next edge returns the FSM to IDLE and clears stall_cycles. Outputs are already at their reset values during the rst cycle.
- Widths: all address compares are full AW bits. cnt width is 4 bits.

Decomposition:
- Shared package hazard_pkg holds:
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the FSM state encoding (IDLE, STALL);
  - the counter width constant.
- Natural sub-module: hazard_fwd_sel, a single-operand forwarding priority selector instantiated twice (operands A and B).

Test Plan:
- Reset: rst=1 with ex_memr=1, ex_rt=id_rs=3 -> pcw=s1w=mux=1, flush=0, fwd=00, stall_cycles=0 throughout the reset.
- Load-use, LOAD_LAT=1: ex_memr=1, ex_rt=5, id_rt=5 for one cycle -> pcw=s1w=mux=0 that cycle only, stall_cycles=1.
- Load-use, LOAD_LAT=3: ex_rt=id_rs=7 for one cycle -> pcw=0 for exactly 3 cycles, then 1, stall_cycles=3. Repeat with ex_rt=id_rs=0 and ZERO_SKIP=1 -> no stall.
- Branch during stall (LOAD_LAT=3): branch_taken=1 on the 2nd stall cycle -> flush=1, pcw=1, mux=0 that cycle, and pcw=1 on the next cycle.
- Forwarding: mem_regw=1, mem_rd=4, wb_regw=1, wb_rd=4, ex_rs_src=4, ex_rt_src=9 -> fwd_a=10, fwd_b=00. Then clear mem_regw -> fwd_a=01.
- Saturation: CW=2, force 5 consecutive stall cycles -> stall_cycles reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the parametrised hazard unit
package hazard_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // bubble counter width; bounds LOAD_LAT to 15
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - single-operand forwarding priority selector
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int ZERO_SKIP = 1
) (
    input  logic [AW-1:0] src,
    input  logic          mem_regw,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_regw,
    input  logic [AW-1:0] wb_rd,
    output logic [1:0]    sel
);

    logic src_ok;

    // $zero is hardwired, so it is never a forwarding candidate when ZERO_SKIP is set
    assign src_ok = (ZERO_SKIP == 0) || (src != '0);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        sel = FWD_RF;
        if (mem_regw && (mem_rd == src) && src_ok) begin
            sel = FWD_MEM;
        end else if (wb_regw && (wb_rd == src) && src_ok) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit_p.sv
// rtl/hazard_unit_p.sv - load-use stall FSM, branch flush, forwarding and stall statistics
module hazard_unit_p
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int LOAD_LAT  = 1,
    parameter int CW        = 16,
    parameter int ZERO_SKIP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          ex_memr,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] ex_rs_src,
    input  logic [AW-1:0] ex_rt_src,
    input  logic          mem_regw,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_regw,
    input  logic [AW-1:0] wb_rd,
    input  logic          branch_taken,
    output logic          pcw,
    output logic          s1w,
    output logic          mux,
    output logic          flush,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [CW-1:0] stall_cycles
);

    // remaining bubbles after the one issued in the detecting IDLE cycle
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    stall_q, stall_d;
    logic             hz;
    logic [1:0]       sel_a, sel_b;

    // load in EX whose destination feeds an ID source operand
    assign hz = ex_memr && ((ex_rt == id_rs) || (ex_rt == id_rt))
                && !((ZERO_SKIP != 0) && (ex_rt == '0));

    hazard_fwd_sel #(.AW(AW), .ZERO_SKIP(ZERO_SKIP)) u_fwd_a (
        .src      (ex_rs_src),
        .mem_regw (mem_regw),
        .mem_rd   (mem_rd),
        .wb_regw  (wb_regw),
        .wb_rd    (wb_rd),
        .sel      (sel_a)
    );

    hazard_fwd_sel #(.AW(AW), .ZERO_SKIP(ZERO_SKIP)) u_fwd_b (
        .src      (ex_rt_src),
        .mem_regw (mem_regw),
        .mem_rd   (mem_rd),
        .wb_regw  (wb_regw),
        .wb_rd    (wb_rd),
        .sel      (sel_b)
    );

    // forwarding selects are held at register-file while in reset
    always_comb begin
        fwd_a = sel_a;
        fwd_b = sel_b;
        if (rst) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end
    end

    // next state and Mealy controls: reset, then branch flush, then stall logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcw     = 1'b1;
        s1w     = 1'b1;
        mux     = 1'b1;
        flush   = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (branch_taken) begin
            // target must load, ID instruction is squashed, any stall is abandoned
            flush   = 1'b1;
            mux     = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz) begin
                        pcw = 1'b0;
                        s1w = 1'b0;
                        mux = 1'b0;
                        if (LOAD_LAT > 1) begin
                            cnt_d   = LAT_M1;
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    // hz is not re-examined until the stall has drained
                    pcw   = 1'b0;
                    s1w   = 1'b0;
                    mux   = 1'b0;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // saturating count of cycles in which the PC was held
    always_comb begin
        stall_d = stall_q;
        if (rst) begin
            stall_d = '0;
        end else if (!pcw && (stall_q != {CW{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit_p.sv
// tb/tb_hazard_unit_p.sv - directed self-checking bench for hazard_unit_p
module tb_hazard_unit_p;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt, ex_rs_src, ex_rt_src, mem_rd, wb_rd;
    logic       ex_memr, mem_regw, wb_regw, branch_taken;

    logic        pcw1, s1w1, mux1, flush1;
    logic [1:0]  fa1, fb1;
    logic [15:0] sc1;
    logic        pcw3, s1w3, mux3, flush3;
    logic [1:0]  fa3, fb3;
    logic [15:0] sc3;
    logic        pcws, s1ws, muxs, flushs;
    logic [1:0]  fas, fbs;
    logic [1:0]  scs;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    hazard_unit_p #(.AW(5), .LOAD_LAT(1), .CW(16), .ZERO_SKIP(1)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memr(ex_memr),
        .ex_rt(ex_rt), .ex_rs_src(ex_rs_src), .ex_rt_src(ex_rt_src),
        .mem_regw(mem_regw), .mem_rd(mem_rd), .wb_regw(wb_regw), .wb_rd(wb_rd),
        .branch_taken(branch_taken), .pcw(pcw1), .s1w(s1w1), .mux(mux1),
        .flush(flush1), .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1)
    );

    hazard_unit_p #(.AW(5), .LOAD_LAT(3), .CW(16), .ZERO_SKIP(1)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memr(ex_memr),
        .ex_rt(ex_rt), .ex_rs_src(ex_rs_src), .ex_rt_src(ex_rt_src),
        .mem_regw(mem_regw), .mem_rd(mem_rd), .wb_regw(wb_regw), .wb_rd(wb_rd),
        .branch_taken(branch_taken), .pcw(pcw3), .s1w(s1w3), .mux(mux3),
        .flush(flush3), .fwd_a(fa3), .fwd_b(fb3), .stall_cycles(sc3)
    );

    hazard_unit_p #(.AW(5), .LOAD_LAT(5), .CW(2), .ZERO_SKIP(1)) us (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memr(ex_memr),
        .ex_rt(ex_rt), .ex_rs_src(ex_rs_src), .ex_rt_src(ex_rt_src),
        .mem_regw(mem_regw), .mem_rd(mem_rd), .wb_regw(wb_regw), .wb_rd(wb_rd),
        .branch_taken(branch_taken), .pcw(pcws), .s1w(s1ws), .mux(muxs),
        .flush(flushs), .fwd_a(fas), .fwd_b(fbs), .stall_cycles(scs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_memr = 0; ex_rt = 0; ex_rs_src = 0; ex_rt_src = 0;
        mem_regw = 0; mem_rd = 0; wb_regw = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] exp_p1, exp_p3, exp_ps;
        logic [1:0] exp_sc3 [6];
        logic [1:0] exp_scs [6];
        exp_p1 = 6'b111110;
        exp_p3 = 6'b111000;
        exp_ps = 6'b100000;
        exp_sc3 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        exp_scs = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // reset with a live hazard and a live forwarding match on the inputs
        clear_inputs();
        rst = 1; ex_memr = 1; ex_rt = 3; id_rs = 3;
        mem_regw = 1; mem_rd = 4; ex_rs_src = 4;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            @(negedge clk);
            check("rst_pcw1", pcw1, 1);
            check("rst_s1w1", s1w1, 1);
            check("rst_mux1", mux1, 1);
            check("rst_flush1", flush1, 0);
            check("rst_fwda1", fa1, 0);
            check("rst_fwdb1", fb1, 0);
            check("rst_sc1", sc1, 0);
            check("rst_pcw3", pcw3, 1);
            check("rst_sc3", sc3, 0);
            check("rst_scs", scs, 0);
        end

        clear_inputs();
        rst = 0;
        edge_step();

        // one-cycle load-use: 1, 3 and 5 bubble instances side by side
        ex_memr = 1; ex_rt = 5; id_rt = 5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("lu_pcw1_%0d", i), pcw1, exp_p1[i]);
            check($sformatf("lu_s1w1_%0d", i), s1w1, exp_p1[i]);
            check($sformatf("lu_pcw3_%0d", i), pcw3, exp_p3[i]);
            check($sformatf("lu_mux3_%0d", i), mux3, exp_p3[i]);
            check($sformatf("lu_pcws_%0d", i), pcws, exp_ps[i]);
            check($sformatf("lu_flush3_%0d", i), flush3, 0);
            edge_step();
            ex_memr = 0; ex_rt = 0; id_rt = 0;
            check($sformatf("lu_sc1_%0d", i), sc1, 1);
            check($sformatf("lu_sc3_%0d", i), sc3, {14'd0, exp_sc3[i]});
            check($sformatf("sat_scs_%0d", i), scs, exp_scs[i]);
        end

        // load into $zero never stalls
        ex_memr = 1; ex_rt = 0; id_rs = 0;
        @(negedge clk);
        check("zero_pcw1", pcw1, 1);
        check("zero_pcw3", pcw3, 1);
        edge_step();
        check("zero_sc3", sc3, 3);
        clear_inputs();

        // branch on the second stall cycle of the 3-bubble instance
        ex_memr = 1; ex_rt = 7; id_rs = 7;
        @(negedge clk);
        check("br_pcw3_c0", pcw3, 0);
        edge_step();
        ex_memr = 0; ex_rt = 0; id_rs = 0; branch_taken = 1;
        @(negedge clk);
        check("br_flush3", flush3, 1);
        check("br_pcw3", pcw3, 1);
        check("br_s1w3", s1w3, 1);
        check("br_mux3", mux3, 0);
        check("br_flush1", flush1, 1);
        edge_step();
        branch_taken = 0;
        @(negedge clk);
        check("br_after_pcw3", pcw3, 1);
        check("br_after_flush3", flush3, 0);
        check("br_sc3", sc3, 4);
        check("br_sc1", sc1, 2);

        // flush beats a simultaneous hazard
        ex_memr = 1; ex_rt = 6; id_rt = 6; branch_taken = 1;
        @(negedge clk);
        check("prio_pcw3", pcw3, 1);
        check("prio_flush3", flush3, 1);
        check("prio_mux3", mux3, 0);
        edge_step();
        clear_inputs();
        @(negedge clk);
        check("prio_after_pcw3", pcw3, 1);
        check("prio_sc3", sc3, 4);

        // forwarding priority
        mem_regw = 1; mem_rd = 4; wb_regw = 1; wb_rd = 4; ex_rs_src = 4; ex_rt_src = 9;
        #1;
        check("fwd_a_mem", fa1, 2'b10);
        check("fwd_b_rf", fb1, 2'b00);
        mem_regw = 0;
        #1;
        check("fwd_a_wb", fa1, 2'b01);
        wb_rd = 9; mem_regw = 1;
        #1;
        check("fwd_a_mem2", fa3, 2'b10);
        check("fwd_b_wb", fb3, 2'b01);
        mem_rd = 0; wb_rd = 0; ex_rs_src = 0; ex_rt_src = 0;
        #1;
        check("fwd_a_zero", fa1, 2'b00);
        check("fwd_b_zero", fb1, 2'b00);
        clear_inputs();

        // reset arriving mid-stall
        edge_step();
        ex_memr = 1; ex_rt = 8; id_rs = 8;
        edge_step();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        check("mrst_pcw3", pcw3, 1);
        check("mrst_mux3", mux3, 1);
        edge_step();
        rst = 0;
        @(negedge clk);
        check("mrst_sc3", sc3, 0);
        check("mrst_after_pcw3", pcw3, 1);
        edge_step();
        check("mrst_sc3_hold", sc3, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
